// File: rtl/pht_ctr_table.sv
// Pattern history table of saturating counters; the table owns the counter read-modify-write.
// Reads are combinational; an accepted update commits one cycle later (visible the cycle after
// that, or one cycle earlier on matching read ports when PHT_UPD_BYPASS_EN is defined).
// Backpressure: o_pht_upd_rdy is low while the init sweep runs after rst or i_pht_clear.
module pht_ctr_table #(
    parameter int unsigned PHT_ENTRIES = 2048,
    parameter int unsigned IDX_WIDTH   = 11,
    parameter int unsigned CTR_WIDTH   = 2,
    parameter int unsigned RD_PORTS    = 4,
    parameter int unsigned INIT_VALUE  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RD_PORTS*IDX_WIDTH-1:0] i_pht_ridx,
    output logic [RD_PORTS*CTR_WIDTH-1:0] o_pht_rd_entry,
    output logic [RD_PORTS-1:0]           o_pht_rd_taken,
    input  logic                          i_pht_upd_vld,
    input  logic [IDX_WIDTH-1:0]          i_pht_upd_idx,
    input  logic                          i_pht_upd_taken,
    output logic                          o_pht_upd_rdy,
    input  logic                          i_pht_clear,
    output logic                          o_pht_init_busy
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] INIT_CTR = CTR_WIDTH'(INIT_VALUE);
    localparam logic [IDX_WIDTH-1:0] SP_LAST  = IDX_WIDTH'(PHT_ENTRIES - 1);

    if (PHT_ENTRIES != (1 << IDX_WIDTH)) begin : g_bad_depth
        $error("pht_ctr_table: PHT_ENTRIES must equal 2**IDX_WIDTH");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q;
    logic [IDX_WIDTH-1:0]   sp_q;
    logic                   busy_q;
    logic                   rdy_q;
    logic                   s1_vld_q;
    logic [IDX_WIDTH-1:0]   s1_idx_q;
    logic                   s1_taken_q;
    logic [CTR_WIDTH-1:0]   mem_q [PHT_ENTRIES];

    logic                   upd_acc;
    logic [CTR_WIDTH-1:0]   s1_cur;
    logic [CTR_WIDTH-1:0]   s1_new_d;

    // rst overrides the registered flags so the block looks busy in the reset cycle itself,
    // not only from the following cycle.
    assign o_pht_init_busy = busy_q | rst;
    assign o_pht_upd_rdy   = rdy_q & ~rst;
    // A clear in the same cycle wins over the update: it is dropped rather than staged.
    assign upd_acc         = i_pht_upd_vld & o_pht_upd_rdy & ~i_pht_clear;

    // Init/run sequencing, sweep pointer, busy/ready flags and stage-1 valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            sp_q     <= '0;
            busy_q   <= 1'b1;
            rdy_q    <= 1'b0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= upd_acc;
            case (state_q)
                ST_INIT: begin
                    sp_q <= sp_q + IDX_WIDTH'(1);
                    if (sp_q == SP_LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_pht_clear) begin
                        state_q <= ST_INIT;
                        sp_q    <= '0;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Stage-1 payload needs no reset; it is qualified by s1_vld_q.
    always_ff @(posedge clk) begin
        if (upd_acc) begin
            s1_idx_q   <= i_pht_upd_idx;
            s1_taken_q <= i_pht_upd_taken;
        end
    end

    // Saturating increment/decrement of the staged entry; no wrap at either end.
    always_comb begin
        s1_cur   = mem_q[s1_idx_q];
        s1_new_d = s1_cur;
        if (s1_taken_q) begin
            if (s1_cur != CTR_MAX) s1_new_d = s1_cur + CTR_WIDTH'(1);
        end else begin
            if (s1_cur != '0) s1_new_d = s1_cur - CTR_WIDTH'(1);
        end
    end

    // Single write port: the sweep owns the array during INIT, stage 1 during RUN.
    // Stage 1 is never valid during INIT, so the two never compete.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_q[sp_q] <= INIT_CTR;
            end else if (s1_vld_q) begin
                mem_q[s1_idx_q] <= s1_new_d;
            end
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [IDX_WIDTH-1:0] ridx;
        logic [CTR_WIDTH-1:0] val;

        assign ridx = i_pht_ridx[p*IDX_WIDTH +: IDX_WIDTH];

        // Per-port read: array value, optional forward of the in-flight update, init override.
        always_comb begin
            val = mem_q[ridx];
`ifdef PHT_UPD_BYPASS_EN
            if (s1_vld_q && (ridx == s1_idx_q)) val = s1_new_d;
`endif
            if (o_pht_init_busy) val = INIT_CTR;
        end

        assign o_pht_rd_entry[p*CTR_WIDTH +: CTR_WIDTH] = val;
        assign o_pht_rd_taken[p]                       = val[CTR_WIDTH-1];
    end

endmodule

// File: tb/tb_pht_ctr_table.sv
// Directed bench for pht_ctr_table with default parameters.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Expectations for the cycle right after an update follow the PHT_UPD_BYPASS_EN build.
module tb_pht_ctr_table;

    localparam int IDXW = 11;
    localparam int CTRW = 2;
    localparam int NP   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP*IDXW-1:0]   ridx;
    logic [NP*CTRW-1:0]   rd_entry;
    logic [NP-1:0]        rd_taken;
    logic                 upd_vld;
    logic [IDXW-1:0]      upd_idx;
    logic                 upd_taken;
    logic                 upd_rdy;
    logic                 clr;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

`ifdef PHT_UPD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    pht_ctr_table dut (
        .clk             (clk),
        .rst             (rst),
        .i_pht_ridx      (ridx),
        .o_pht_rd_entry  (rd_entry),
        .o_pht_rd_taken  (rd_taken),
        .i_pht_upd_vld   (upd_vld),
        .i_pht_upd_idx   (upd_idx),
        .i_pht_upd_taken (upd_taken),
        .o_pht_upd_rdy   (upd_rdy),
        .i_pht_clear     (clr),
        .o_pht_init_busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ridx(input int p, input logic [IDXW-1:0] idx);
        ridx[p*IDXW +: IDXW] = idx;
    endtask

    function automatic logic [CTRW-1:0] ent(input int p);
        return rd_entry[p*CTRW +: CTRW];
    endfunction

    // Counts busy cycles from the current one; also counts cycles where rdy was high while busy.
    task automatic measure_busy(output int n, output int rdy_bad);
        n = 0;
        rdy_bad = 0;
        while (busy === 1'b1 && n < 3000) begin
            if (upd_rdy !== 1'b0) rdy_bad++;
            n++;
            tick();
        end
    endtask

    int n, rb;

    initial begin
        rst = 1'b1; ridx = '0; upd_vld = 1'b0; upd_idx = '0; upd_taken = 1'b0; clr = 1'b0;
        set_ridx(0, 11'd5); set_ridx(1, 11'd100); set_ridx(2, 11'd2047); set_ridx(3, 11'd0);
        tick(); tick(); tick();

        // ---- reset state ----
        chk("rst_busy", busy, 1);
        chk("rst_rdy", upd_rdy, 0);
        chk("rst_entry0", ent(0), 1);
        chk("rst_entry2", ent(2), 1);

        // ---- initial sweep: 2048 busy cycles, rdy low throughout ----
        rst = 1'b0;
        #1;
        measure_busy(n, rb);
        chk("init_len", n, 2048);
        chk("init_rdy_low", rb, 0);
        chk("run_busy", busy, 0);
        chk("run_rdy", upd_rdy, 1);
        for (int p = 0; p < NP; p++) set_ridx(p, IDXW'($urandom_range(0, 2047)));
        #1;
        chk("rand_reads", rd_entry, {NP{2'd1}});
        chk("rand_taken", rd_taken, 4'b0000);

        // ---- three taken updates to idx 5: 2, 3, 3 ----
        set_ridx(0, 11'd5); set_ridx(1, 11'd4); set_ridx(2, 11'd6);
        upd_vld = 1'b1; upd_idx = 11'd5; upd_taken = 1'b1;
        #1;
        chk("sat_t0", ent(0), 1);
        tick();
        #1;
        chk("sat_t1", ent(0), BYP ? 2 : 1);
        tick();
        #1;
        chk("sat_t2", ent(0), BYP ? 3 : 2);
        tick();
        upd_vld = 1'b0;
        #1;
        chk("sat_t3", ent(0), 3);
        tick();
        #1;
        chk("sat_t4", ent(0), 3);
        chk("sat_taken", rd_taken[0], 1);
        chk("nbr_idx4", ent(1), 1);
        chk("nbr_idx6", ent(2), 1);

        // ---- two not-taken updates to idx 0x7FF: floor at 0 ----
        set_ridx(3, 11'h7FF);
        upd_vld = 1'b1; upd_idx = 11'h7FF; upd_taken = 1'b0;
        tick();
        #1;
        chk("floor_t1", ent(3), BYP ? 0 : 1);
        tick();
        upd_vld = 1'b0;
        #1;
        chk("floor_t2", ent(3), 0);
        tick();
        #1;
        chk("floor_t3", ent(3), 0);
        chk("floor_taken", rd_taken[3], 0);

        // ---- update idx 9, port 2 watches the bypass window ----
        set_ridx(2, 11'd9);
        upd_vld = 1'b1; upd_idx = 11'd9; upd_taken = 1'b1;
        #1;
        chk("byp_t0", ent(2), 1);
        tick();
        upd_vld = 1'b0;
        #1;
        chk("byp_t1", ent(2), BYP ? 2 : 1);
        tick();
        #1;
        chk("byp_t2", ent(2), 2);
        chk("byp_taken", rd_taken[2], 1);

        // ---- update idx 3 together with clear: sweep restarts, update discarded ----
        set_ridx(0, 11'd5); set_ridx(1, 11'd3);
        upd_vld = 1'b1; upd_idx = 11'd3; upd_taken = 1'b0; clr = 1'b1;
        #1;
        chk("clr_t_busy", busy, 0);
        tick();
        upd_vld = 1'b0; clr = 1'b0;
        #1;
        chk("clr_t1_busy", busy, 1);
        chk("clr_t1_rdy", upd_rdy, 0);
        chk("clr_t1_idx5", ent(0), 1);
        // Clear pulse and an update attempt mid-sweep must both be ignored.
        n = 0;
        rb = 0;
        while (busy === 1'b1 && n < 3000) begin
            if (upd_rdy !== 1'b0) rb++;
            if (n == 100) clr = 1'b1;
            if (n == 200) begin
                upd_vld = 1'b1; upd_idx = 11'd3; upd_taken = 1'b0;
            end
            n++;
            tick();
            clr = 1'b0;
            upd_vld = 1'b0;
        end
        #1;
        chk("clr_len", n, 2048);
        chk("clr_rdy_low", rb, 0);
        set_ridx(2, 11'h7FF); set_ridx(3, 11'd9);
        #1;
        chk("clr_idx3", ent(1), 1);
        chk("clr_idx5", ent(0), 1);
        chk("clr_idx7ff", ent(2), 1);
        chk("clr_idx9", ent(3), 1);

        // ---- rst while running, then rst again at sweep cycle 1000 ----
        rst = 1'b1;
        #1;
        chk("rst_run_busy", busy, 1);
        chk("rst_run_rdy", upd_rdy, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1);
        tick();
        rst = 1'b0;
        #1;
        measure_busy(n, rb);
        chk("rst_mid_len", n, 2048);
        chk("rst_mid_rdy_low", rb, 0);
        chk("final_rdy", upd_rdy, 1);
        chk("final_idx3", ent(1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
